// File: rtl/alu_flag_pipe_if.sv
// Handshake bundle for alu_flag_pipe: operation input, result output, flush.
// Signals: in_valid/in_ready/op/a/b (offer), out_valid/out_ready/result/wr_en (retire), z_flag/c_flag, flush.
// Modports: master drives operations and consumes results; slave is the pipeline.
interface alu_flag_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             wr_en;
    logic             z_flag;
    logic             c_flag;

    modport master (
        output in_valid, op, a, b, flush, out_ready,
        input  in_ready, out_valid, result, wr_en, z_flag, c_flag
    );

    modport slave (
        input  in_valid, op, a, b, flush, out_ready,
        output in_ready, out_valid, result, wr_en, z_flag, c_flag
    );
endinterface

// File: rtl/alu_flag_pipe.sv
// Two-stage ALU with zero/carry flags committed at retirement; conditional ops read the effective flags.
// Latency: 2 cycles from accepted input to out_valid when unstalled.
// Backpressure: out_ready low holds S2 stable and stalls S1; in_ready drops when S1 cannot drain or flush is high.
// Ports: clk, rst_n (synchronous, active-low), bus (alu_flag_pipe_if.slave).
// Build option: define ALU_FLAG_FWD_EN to forward S2 pending flags into S1 condition evaluation,
// removing the conditional-after-flag-setter interlock bubble.
module alu_flag_pipe #(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_flag_pipe_if.slave bus
);
    // Stage 1: captured operation
    logic             r_s1_vld;
    logic [5:0]       r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    // Stage 2: computed result plus pending flags and which flags it writes
    logic             r_s2_vld;
    logic [WIDTH-1:0] r_result;
    logic             r_wr_en;
    logic             r_s2_z;
    logic             r_s2_c;
    logic             r_s2_setz;
    logic             r_s2_setc;
    // Committed flags
    logic             r_z_flag;
    logic             r_c_flag;

    logic [3:0]       w_opc;
    logic [1:0]       w_cond;
    logic             w_z_eff;
    logic             w_c_eff;
    logic             w_stall;
    logic             w_retire;
    logic             w_s2_free;
    logic             w_s1_adv;
    logic             w_in_rdy;
    logic             w_in_xfer;
    logic             w_cond_ok;
    logic [WIDTH:0]   w_sum_ab;
    logic [WIDTH:0]   w_sum_ab2;
    logic [WIDTH-1:0] w_res;
    logic             w_wr;
    logic             w_cout;
    logic             w_setz;
    logic             w_setc;

    assign w_opc  = r_s1_op[5:2];
    assign w_cond = r_s1_op[1:0];

`ifdef ALU_FLAG_FWD_EN
    // A flag-setting op still in S2 retires before the S1 op, so its pending flags are the truth.
    assign w_z_eff = (r_s2_vld && r_s2_setz) ? r_s2_z : r_z_flag;
    assign w_c_eff = (r_s2_vld && r_s2_setc) ? r_s2_c : r_c_flag;
    assign w_stall = 1'b0;
`else
    logic w_s1_is_cond;
    assign w_z_eff = r_z_flag;
    assign w_c_eff = r_c_flag;
    // Only ADD/NAND with cond 01/10 read flags; NAND cond 11 decodes as an unknown opcode.
    assign w_s1_is_cond = ((w_opc == 4'b0001) || (w_opc == 4'b0010)) &&
                          ((w_cond == 2'b01) || (w_cond == 2'b10));
    // Hold the conditional op even when S2 retires this edge: committed flags update only after it.
    assign w_stall = r_s1_vld && w_s1_is_cond && r_s2_vld && (r_s2_setz || r_s2_setc);
`endif

    assign w_retire  = r_s2_vld && bus.out_ready;
    assign w_s2_free = !r_s2_vld || w_retire;
    assign w_s1_adv  = r_s1_vld && w_s2_free && !w_stall;
    assign w_in_rdy  = !bus.flush && (!r_s1_vld || w_s1_adv);
    assign w_in_xfer = bus.in_valid && w_in_rdy;

    assign w_sum_ab  = {1'b0, r_s1_a} + {1'b0, r_s1_b};
    assign w_sum_ab2 = {1'b0, r_s1_a} + {1'b0, r_s1_b[WIDTH-2:0], 1'b0};
    assign w_cond_ok = (w_cond == 2'b00) || (w_cond == 2'b11) ||
                       ((w_cond == 2'b01) && w_z_eff) || ((w_cond == 2'b10) && w_c_eff);

    always_comb begin
        w_res  = '0;
        w_wr   = 1'b1;
        w_cout = 1'b0;
        w_setz = 1'b0;
        w_setc = 1'b0;
        case (w_opc)
            4'b0001: begin
                if (w_cond_ok) begin
                    w_res  = (w_cond == 2'b11) ? w_sum_ab2[WIDTH-1:0] : w_sum_ab[WIDTH-1:0];
                    w_cout = (w_cond == 2'b11) ? w_sum_ab2[WIDTH] : w_sum_ab[WIDTH];
                    w_setz = 1'b1;
                    w_setc = 1'b1;
                end else begin
                    w_wr = 1'b0;
                end
            end
            4'b0010: begin
                if (w_cond == 2'b11) begin
                    w_res = WIDTH'(1);
                end else if (w_cond_ok) begin
                    w_res  = ~(r_s1_a & r_s1_b);
                    w_setz = 1'b1;
                end else begin
                    w_wr = 1'b0;
                end
            end
            4'b0000: begin
                w_res  = w_sum_ab[WIDTH-1:0];
                w_cout = w_sum_ab[WIDTH];
                w_setz = 1'b1;
                w_setc = 1'b1;
            end
            4'b0011:                            w_res = r_s1_a;
            4'b1000:                            w_res = r_s1_a ^ r_s1_b;
            4'b0100, 4'b0101:                   w_res = w_sum_ab[WIDTH-1:0];
            4'b1100, 4'b1101, 4'b1110, 4'b1111: w_res = r_s1_b;
            default:                            w_res = WIDTH'(1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_op   <= '0;
            r_s1_a    <= '0;
            r_s1_b    <= '0;
            r_s2_vld  <= 1'b0;
            r_result  <= '0;
            r_wr_en   <= 1'b0;
            r_s2_z    <= 1'b0;
            r_s2_c    <= 1'b0;
            r_s2_setz <= 1'b0;
            r_s2_setc <= 1'b0;
            r_z_flag  <= 1'b0;
            r_c_flag  <= 1'b0;
        end else begin
            // A retiring op commits its flags even when flush hits the same edge.
            if (w_retire) begin
                if (r_s2_setz) r_z_flag <= r_s2_z;
                if (r_s2_setc) r_c_flag <= r_s2_c;
            end
            if (bus.flush) begin
                r_s1_vld <= 1'b0;
                r_s2_vld <= 1'b0;
            end else begin
                if (w_in_xfer) begin
                    r_s1_vld <= 1'b1;
                    r_s1_op  <= bus.op;
                    r_s1_a   <= bus.a;
                    r_s1_b   <= bus.b;
                end else if (w_s1_adv) begin
                    r_s1_vld <= 1'b0;
                end
                if (w_s1_adv) begin
                    r_s2_vld  <= 1'b1;
                    r_result  <= w_res;
                    r_wr_en   <= w_wr;
                    r_s2_z    <= (w_res == '0);
                    r_s2_c    <= w_cout;
                    r_s2_setz <= w_setz;
                    r_s2_setc <= w_setc;
                end else if (w_retire) begin
                    r_s2_vld <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_rdy;
    assign bus.out_valid = r_s2_vld;
    assign bus.result    = r_result;
    assign bus.wr_en     = r_wr_en;
    assign bus.z_flag    = r_z_flag;
    assign bus.c_flag    = r_c_flag;
endmodule
